// File: rtl/mul8_pkg.sv
// Shared types and per-step constants for the nibble-serial 8x8 multiplier.
package mul8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mul8_state_t;

    localparam int MUL8_STEPS = 4;

    localparam logic [1:0] MUL8_STEP_LAST = 2'(MUL8_STEPS - 1);

    // Bit n selects the high nibble for step n.
    localparam logic [3:0] MUL8_A_HI = 4'b1100;
    localparam logic [3:0] MUL8_B_HI = 4'b1010;

    function automatic logic [3:0] mul8_shift(input logic [1:0] step);
        logic [3:0] sh;
        sh = 4'd0;
        unique case (step)
            2'd0: sh = 4'd0;
            2'd1: sh = 4'd4;
            2'd2: sh = 4'd4;
            2'd3: sh = 4'd8;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mul8_nibble_seq_mult4.sv
// 4x4 unsigned combinational multiplier built from shifted AND rows.
module Multiple_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    always_comb begin
        p = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                p = p + (8'(a) << i);
            end
        end
    end

endmodule

// File: rtl/mul8_nibble_seq.sv
// Sequential 8x8 unsigned multiplier: four nibble partial products
// through one shared 4x4 multiplier, shift-accumulated into 16 bits.
module mul8_nibble_seq
    import mul8_pkg::*;
#(
    parameter int PIPE_PP = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);

    mul8_state_t state;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc;
    logic [1:0]  step;
    logic [7:0]  pp_q;
    logic [3:0]  sh_q;
    logic        pp_vld;
    logic        pp_done;

    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [7:0]  pp;
    logic [3:0]  shift;
    logic [15:0] term;
    logic [15:0] sum;
    logic        acc_en;
    logic        load_en;
    logic        last;

    assign a_nib = MUL8_A_HI[step] ? a_q[7:4] : a_q[3:0];
    assign b_nib = MUL8_B_HI[step] ? b_q[7:4] : b_q[3:0];
    assign shift = mul8_shift(step);

    Multiple_4bit u_mult (
        .a (a_nib),
        .b (b_nib),
        .p (pp)
    );

    // With the pp register, accumulation trails the load by one edge.
    assign term    = (PIPE_PP != 0) ? (16'(pp_q) << sh_q)
                                    : (16'(pp) << shift);
    assign sum     = acc + term;
    assign acc_en  = (PIPE_PP != 0) ? pp_vld : 1'b1;
    assign load_en = (PIPE_PP != 0) ? !pp_done : 1'b1;
    assign last    = (PIPE_PP != 0) ? pp_done
                                    : (step == MUL8_STEP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            acc       <= 16'd0;
            step      <= 2'd0;
            pp_q      <= 8'd0;
            sh_q      <= 4'd0;
            pp_vld    <= 1'b0;
            pp_done   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= 16'd0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        acc      <= 16'd0;
                        step     <= 2'd0;
                        pp_vld   <= 1'b0;
                        pp_done  <= 1'b0;
                        state    <= MUL;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                MUL: begin
                    if (load_en) begin
                        pp_q   <= pp;
                        sh_q   <= shift;
                        pp_vld <= 1'b1;
                        if (step == MUL8_STEP_LAST) begin
                            pp_done <= 1'b1;
                        end else begin
                            step <= step + 2'd1;
                        end
                    end
                    if (acc_en) begin
                        acc <= sum;
                    end
                    if (last) begin
                        product   <= sum;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul8_nibble_seq.sv
// Directed and random checks of mul8_nibble_seq, both PIPE_PP settings.
module tb_mul8_nibble_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [7:0]  a         [2];
    logic [7:0]  b         [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [15:0] product   [2];
    logic        busy      [2];

    int errors;
    int checks;

    mul8_nibble_seq #(.PIPE_PP(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .a         (a[0]),
        .b         (b[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .product   (product[0]),
        .busy      (busy[0])
    );

    mul8_nibble_seq #(.PIPE_PP(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .a         (a[1]),
        .b         (b[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .product   (product[1]),
        .busy      (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int u, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid[u] && n < 20);
    endtask

    task automatic run_op(input int u, input logic [7:0] x,
                          input logic [7:0] y, input logic [15:0] exp,
                          input int lat, input int stall,
                          input string tag);
        int n;
        a[u]         = x;
        b[u]         = y;
        in_valid[u]  = 1'b1;
        out_ready[u] = (stall == 0);
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        check({tag, "_in_ready_lo"}, 32'(in_ready[u]), 32'd0);
        wait_valid(u, n);
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_product"}, 32'(product[u]), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            a[u] = ~x;
            b[u] = y + 8'd1;
            @(posedge clk);
            #1;
            check({tag, "_stall_valid"}, 32'(out_valid[u]), 32'd1);
            check({tag, "_stall_in_ready"}, 32'(in_ready[u]), 32'd0);
            check({tag, "_stall_product"}, 32'(product[u]), 32'(exp));
        end
        out_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_hs_valid_lo"}, 32'(out_valid[u]), 32'd0);
        check({tag, "_hs_in_ready"}, 32'(in_ready[u]), 32'd1);
    endtask

    initial begin
        int n;
        logic [7:0] x;
        logic [7:0] y;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u]  = 1'b0;
            out_ready[u] = 1'b1;
            a[u]         = 8'd0;
            b[u]         = 8'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("rst_in_ready", 32'(in_ready[u]), 32'd1);
            check("rst_out_valid", 32'(out_valid[u]), 32'd0);
            check("rst_product", 32'(product[u]), 32'd0);
            check("rst_busy", 32'(busy[u]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(0, 8'h12, 8'h34, 16'h03A8, 4, 0, "basic");
        run_op(0, 8'hFF, 8'hFF, 16'hFE01, 4, 0, "ff_p0");
        run_op(1, 8'hFF, 8'hFF, 16'hFE01, 5, 0, "ff_p1");
        run_op(1, 8'h12, 8'h34, 16'h03A8, 5, 0, "basic_p1");

        // Second pair waits on in_valid while the first is in flight.
        a[0]         = 8'h00;
        b[0]         = 8'hAB;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        a[0] = 8'hF0;
        b[0] = 8'h0F;
        check("b2b_in_ready_lo", 32'(in_ready[0]), 32'd0);
        wait_valid(0, n);
        check("b2b_lat1", 32'(n), 32'd4);
        check("b2b_prod1", 32'(product[0]), 32'h0000);
        @(posedge clk);
        #1;
        check("b2b_in_ready_hi", 32'(in_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        check("b2b_accept2", 32'(in_ready[0]), 32'd0);
        wait_valid(0, n);
        check("b2b_lat2", 32'(n), 32'd4);
        check("b2b_prod2", 32'(product[0]), 32'h0E10);
        @(posedge clk);
        #1;

        run_op(0, 8'h9C, 8'h27, 16'h17C4, 4, 5, "bp_p0");
        run_op(1, 8'h9C, 8'h27, 16'h17C4, 5, 5, "bp_p1");

        // Abort during MUL step 2, asserted between edges.
        for (int u = 0; u < 2; u++) begin
            a[u]        = 8'hAA;
            b[u]        = 8'h55;
            in_valid[u] = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            check("abort_out_valid", 32'(out_valid[u]), 32'd0);
            check("abort_product", 32'(product[u]), 32'd0);
            check("abort_busy", 32'(busy[u]), 32'd0);
            check("abort_in_ready", 32'(in_ready[u]), 32'd1);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_no_pulse0", 32'(out_valid[0]), 32'd0);
            check("abort_no_pulse1", 32'(out_valid[1]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(0, 8'h03, 8'h05, 16'h000F, 4, 0, "post_rst_p0");
        run_op(1, 8'h03, 8'h05, 16'h000F, 5, 0, "post_rst_p1");

        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            run_op(i % 2, x, y, 16'(x) * 16'(y), 4 + (i % 2),
                   int'($urandom_range(0, 2)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mul8_nibble_seq.md
# mul8_nibble_seq

Sequential 8x8 unsigned multiplier stage for the 8-bit ALU multiply path. It accepts two 8-bit operands over a valid/ready handshake, splits them into nibbles, and feeds four 4x4 partial products through one shared 4-bit multiplier, one per cycle. It shift-accumulates the partial products into a 16-bit product and presents the result on an output valid/ready handshake to the ALU result mux.

## Interface
- `PIPE_PP`, default 0: 1 inserts a register on the 4x4 partial-product output, adding one cycle of latency. 0 accumulates the partial product combinationally in the same cycle.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operands `a`/`b` valid.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a`  in  8  multiplicand, unsigned.
- `b`  in  8  multiplier, unsigned.
- `out_valid`  out  1  `product` valid; high only in DONE.
- `out_ready`  in  1  consumer accepts `product`.
- `product`  out  16  unsigned a*b.
- `busy`  out  1  state is not IDLE.

## Operation
- States:
  - IDLE: `in_ready`=1. On `in_valid`&`in_ready`, latch `a` and `b`, clear `acc`, set `step`=0, go to MUL.
  - MUL: one partial product per step.
    - step 0: aL*bL, shifted by 0.
    - step 1: aL*bH, shifted by 4.
    - step 2: aH*bL, shifted by 4.
    - step 3: aH*bH, shifted by 8.
    - Each step does `acc += pp << shift`, 16-bit.
    - After the last accumulate, go to DONE.
  - DONE: `out_valid`=1 and `product`=`acc`, held stable. On `out_ready`, go to IDLE.
- Arithmetic: `pp` is 8 bits and `acc` is 16 bits. No overflow is possible (max 0xFF*0xFF = 0xFE01), so the accumulate carry-out is ignored.
- Operand latches are not updated outside the IDLE accept. Input changes while `busy`=1 have no effect.
- `in_ready` is not asserted in DONE. A new operand pair is accepted only after the result handshake completes and the block has returned to IDLE.
- Reset values:
  - state IDLE, `acc`=0, `step`=0, operand latches 0, pp register 0.
  - `out_valid`=0, `product`=0, `busy`=0.
  - `in_ready`=1 while in IDLE, including during reset. Handshakes are not sampled while `rst_n`=0.
- Reset asserted mid-MUL or in DONE aborts the operation immediately and asynchronously. No partial result is ever presented.

## Timing
- The accept edge is edge 0.
- `PIPE_PP`=0: MUL occupies edges 1–4, and `out_valid` rises after edge 4.
- `PIPE_PP`=1: MUL occupies edges 1–5. The pp register is loaded at edges 1–4 and accumulated at edges 2–5. `out_valid` rises after edge 5.
- The result handshake completes on the first edge with `out_valid`&`out_ready`. `in_ready` is high from the following cycle.
- Minimum initiation interval: 6 cycles (`PIPE_PP`=0) or 7 cycles (`PIPE_PP`=1), with `out_ready` held at 1.
- `product` changes only on entry to DONE and is held while `out_ready`=0.
- Step counter: 2 bits, no wrap beyond 3; at step 3 the FSM exits to DONE.

## Structure
- Shared package `mul8_pkg` holds:
  - state enum `mul8_state_t` {IDLE, MUL, DONE};
  - `MUL8_STEPS` = 4;
  - the per-step nibble-select and shift constants (0, 4, 4, 8).
- Sub-module: one instance of the existing 4x4 combinational multiplier `Multiple_4bit`, driven by the nibble muxes. It is the only multiplier in the block.
- Accumulator add is a plain 16-bit adder in this module.

## Test plan
- Reset release, `a`=0x12, `b`=0x34, `out_ready`=1, `PIPE_PP`=0:
  - `in_ready` drops after the accept edge;
  - `out_valid` rises after edge 4 with `product`=0x03A8;
  - `in_ready` returns one cycle after the result handshake.
- `a`=0xFF, `b`=0xFF, run with `PIPE_PP`=0 and again with `PIPE_PP`=1:
  - `product`=0xFE01;
  - latency is 4 and 5 cycles respectively.
- `a`=0x00, `b`=0xAB, then `a`=0xF0, `b`=0x0F, issued back to back:
  - products are 0x0000 then 0x0E10;
  - second `in_valid` is held high while `in_ready` is low and is accepted only after the first handshake.
- Backpressure:
  - `a`=0x9C, `b`=0x27, `out_ready`=0 for 5 cycles;
  - `product`=0x17C4 is stable and `out_valid` stays 1 throughout;
  - `in_ready`=0 throughout;
  - changing `a`/`b` during the stall does not alter `product`.
- Reset mid-op:
  - assert `rst_n`=0 at MUL step 2;
  - all outputs take reset values immediately, with no `out_valid` pulse;
  - the next operation, `a`=0x03, `b`=0x05, yields 0x000F.
- Random: 1000 pairs with random `out_ready` stalls. Every `product` equals `a*b` and results appear in order.
